ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width; depth is 2**ADDR_W, 64 by default.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req0/req1, input, 1 each, access request from requester 0 and requester 1.
REQ-006 SHALL have ports we0/we1, input, 1 each, 1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1, input, ADDR_W each, and wdata0/wdata1, input, DATA_W each.
REQ-008 SHALL have ports gnt0/gnt1, output, 1 each, command-accepted pulse.
REQ-009 SHALL have ports rvalid0/rvalid1, output, 1 each, and rdata0/rdata1, output, DATA_W each, read return.
REQ-010 SHALL have ports ram_en, ram_we (output, 1), ram_addr (output, ADDR_W), ram_din (output, DATA_W) and ram_dout (input, DATA_W), to a synchronous single-port RAM with 1-cycle read latency.
REQ-011 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, RDATA (plus INIT, see Configuration).
REQ-013 IDLE: if any reqN=1, pick a winner, latch its we/addr/wdata and go to ISSUE; otherwise stay.
REQ-014 ISSUE: drive ram_en=1 and ram_we/ram_addr/ram_din from the latch; gnt of the winner =1 for exactly this cycle; go to RDATA if read, else IDLE.
REQ-015 RDATA: rvalidN=1 for the winner for one cycle, with rdataN=ram_dout; go to IDLE.
REQ-016 Latency SHALL be a write 2 cycles from IDLE sample to IDLE, and a read 3 cycles, with rvalid 2 cycles after the sampling edge.
REQ-017 Requesters SHALL hold req, we, addr and wdata stable until gnt; req still high in the cycle after gnt is a new request.
REQ-018 Arbitration SHALL be round-robin on a last-grant pointer: a single request wins; on a tie, the requester not granted last wins; the pointer updates on every grant.
REQ-019 Requests arriving in ISSUE/RDATA SHALL be ignored until IDLE; no queuing.
REQ-020 ram_en, ram_we and all gnt/rvalid SHALL be 0 outside ISSUE/RDATA; rdataN SHALL hold its last value when rvalidN=0.
REQ-021 Only one of gnt0/gnt1 SHALL be high in any cycle; likewise for rvalid0/rvalid1.

Reset
REQ-022 rst=0 SHALL asynchronously force IDLE (or INIT), the pointer to "last=1" so that requester 0 wins the first tie, and all outputs to 0.
REQ-023 Reset mid-transaction SHALL abandon it: no gnt or rvalid issued afterwards for it; a write abandoned in ISSUE has undefined RAM effect.

Configuration
REQ-024 Macro RAM_ARBITER_INIT_EN SHALL control the INIT state.
REQ-025 With RAM_ARBITER_INIT_EN defined, reset exit SHALL enter INIT and write 0 to addresses 0..2**ADDR_W-1, one per cycle (ram_en=ram_we=1); busy=1; no grants; go to IDLE after the last address.
REQ-026 With RAM_ARBITER_INIT_EN undefined, reset exit SHALL go directly to IDLE, and RAM contents are untouched.

Structure
REQ-027 Package ram_arbiter_pkg SHALL hold ADDR_W/DATA_W defaults, DEPTH and the FSM state enum.
REQ-028 Round-robin pick SHALL be the sub-module rr_arb2 (inputs req[1:0], last; output winner), purely combinational.

Verification
REQ-029 req0 writes 0xA5 to addr 0x10, then req0 reads 0x10 -> gnt0 pulses twice, rvalid0=1 with rdata0=0xA5 exactly 2 cycles after the read sampling edge.
REQ-030 req0 and req1 held high continuously, all reads -> grants alternate 0,1,0,1, starting with 0 after reset.
REQ-031 req1 alone writes 0x3C to addr 63, then reads 63 -> rdata1=0x3C, rvalid0 stays 0.
REQ-032 rst pulsed low during RDATA of a read -> no rvalid; busy=0 and outputs 0 immediately; next request serviced normally.
REQ-033 With RAM_ARBITER_INIT_EN: preload addr 5=0xFF, reset, then read addr 5 -> busy for 64 cycles, req0 not granted during INIT, then rdata0=0x00.
REQ-034 req1 raised during ISSUE of a req0 write -> gnt1 is not asserted until the FSM returns to IDLE, 1 cycle later.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared defaults and FSM state encoding for the two-port RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned DefAddrW = 6;
  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDepth = 2 ** DefAddrW;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StRdata = 2'd2,
    StInit  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the one not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  // Combinational winner select.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one synchronous single-port RAM (1-cycle read latency).
// Optional: define RAM_ARBITER_INIT_EN to zero the whole RAM after every reset.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              winner;
`ifdef RAM_ARBITER_INIT_EN
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic              init_done_q, init_done_d;
`endif

  rr_arb2 u_rr_arb2 (
    .req    ({req1, req0}),
    .last   (last_q),
    .winner (winner)
  );

  // State, command latch, round-robin pointer and held read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;  // requester 0 wins the first tie
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef RAM_ARBITER_INIT_EN
      init_addr_q <= '0;
      init_done_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef RAM_ARBITER_INIT_EN
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
`endif
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rvalid0  = 1'b0;
    rvalid1  = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
`ifdef RAM_ARBITER_INIT_EN
    init_addr_d = init_addr_q;
    init_done_d = init_done_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef RAM_ARBITER_INIT_EN
        // Reset holds us in IDLE with outputs quiet; the clear sweep starts on the first edge.
        if (!init_done_q) begin
          state_d = StInit;
        end else
`endif
        if (req0 || req1) begin
          win_d   = winner;
          we_d    = winner ? we1 : we0;
          addr_d  = winner ? addr1 : addr0;
          wdata_d = winner ? wdata1 : wdata0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        ram_en   = 1'b1;
        ram_we   = we_q;
        ram_addr = addr_q;
        ram_din  = wdata_q;
        gnt0     = ~win_q;
        gnt1     = win_q;
        last_d   = win_q;
        state_d  = we_q ? StIdle : StRdata;
      end
      StRdata: begin
        rvalid0 = ~win_q;
        rvalid1 = win_q;
        if (win_q) rdata1_d = ram_dout;
        else       rdata0_d = ram_dout;
        state_d = StIdle;
      end
      StInit: begin
`ifdef RAM_ARBITER_INIT_EN
        ram_en      = 1'b1;
        ram_we      = 1'b1;
        ram_addr    = init_addr_q;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == {ADDR_W{1'b1}}) begin
          init_done_d = 1'b1;
          state_d     = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
    // Read data is live during the return cycle and held afterwards.
    rdata0 = rdata0_d;
    rdata1 = rdata1_d;
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle-latency RAM.
// Exercises the INIT sweep only when RAM_ARBITER_INIT_EN is defined.
module tb_ram_arbiter;

  logic       clk, rst;
  logic       req0, req1, we0, we1;
  logic [5:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_en, ram_we;
  logic [5:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic       busy;

  logic       pre_en;
  logic [5:0] pre_addr;
  logic [7:0] pre_data;
  logic [7:0] mem [64];

  int n_checks;
  int n_errors;

  ram_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, read-before-write, plus a bench-side preload port.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy; i++) tick();
    check(tag, busy, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    wait_idle("reset_idle");
  endtask

  int   grants[$];
  logic both_rv;
  logic seen;
  int   cnt;
  logic init_ok;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    {req0, req1, we0, we1} = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    ram_dout = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    // Reset state: everything quiet while rst is low.
    #1 rst = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_gnt", {gnt0, gnt1}, 0);
    check("rst_rvalid", {rvalid0, rvalid1}, 0);
    check("rst_ram_en", {ram_en, ram_we}, 0);
    check("rst_rdata", {rdata0, rdata1}, 0);
    #10 rst = 1'b1;
    tick();
    wait_idle("rst_exit_idle");

    // Both requesters reading continuously: grants alternate starting with 0.
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 6'd0; addr1 = 6'd1;
    both_rv = 1'b0;
    for (int i = 0; i < 30 && grants.size() < 4; i++) begin
      tick();
      if (gnt0 && gnt1) grants.push_back(9);
      else if (gnt0) grants.push_back(0);
      else if (gnt1) grants.push_back(1);
      if (rvalid0 && rvalid1) both_rv = 1'b1;
    end
    req0 = 0; req1 = 0;
    check("rr_count", grants.size(), 4);
    foreach (grants[i]) check($sformatf("rr_grant%0d", i), grants[i], i % 2);
    check("rvalid_onehot", both_rv, 0);
    wait_idle("rr_idle");

    // Requester 0: write 0xA5 to 0x10, then read it back.
    req0 = 1; we0 = 1; addr0 = 6'h10; wdata0 = 8'hA5;
    tick();
    check("w0_gnt", {gnt0, gnt1}, 2'b10);
    check("w0_ram", {ram_en, ram_we, ram_addr, ram_din}, {1'b1, 1'b1, 6'h10, 8'hA5});
    req0 = 0;
    tick();
    check("w0_done", {busy, gnt0}, 0);
    req0 = 1; we0 = 0;
    tick();
    check("r0_gnt", gnt0, 1);
    check("r0_ram", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 6'h10});
    req0 = 0;
    tick();
    check("r0_rvalid", {rvalid0, rvalid1}, 2'b10);
    check("r0_rdata", rdata0, 8'hA5);
    tick();
    check("r0_rvalid_off", {rvalid0, busy}, 0);
    check("r0_rdata_hold", rdata0, 8'hA5);

    // Requester 1 alone: write 0x3C to 63, read it back.
    req1 = 1; we1 = 1; addr1 = 6'd63; wdata1 = 8'h3C;
    tick();
    check("w1_gnt", {gnt0, gnt1}, 2'b01);
    req1 = 0;
    tick();
    req1 = 1; we1 = 0;
    tick();
    check("r1_gnt", {gnt0, gnt1}, 2'b01);
    req1 = 0;
    tick();
    check("r1_rvalid", {rvalid0, rvalid1}, 2'b01);
    check("r1_rdata", rdata1, 8'h3C);
    tick();
    check("r1_after", {rvalid0, rvalid1, busy}, 0);

    // req1 raised during ISSUE of a req0 write waits for IDLE.
    req0 = 1; we0 = 1; addr0 = 6'd2; wdata0 = 8'h5A;
    tick();
    check("ov_gnt0", gnt0, 1);
    req0 = 0;
    req1 = 1; we1 = 0; addr1 = 6'd63;
    check("ov_no_gnt1_issue", gnt1, 0);
    tick();
    check("ov_no_gnt1_idle", {gnt1, busy}, 0);
    tick();
    check("ov_gnt1", {gnt0, gnt1}, 2'b01);
    req1 = 0;
    tick();
    check("ov_rdata1", {rvalid1, rdata1}, {1'b1, 8'h3C});
    tick();

    // Reset during RDATA abandons the read.
    req0 = 1; we0 = 0; addr0 = 6'h10;
    tick();
    req0 = 0;
    tick();
    check("ab_rvalid_pre", rvalid0, 1);
    #2 rst = 1'b0;
    #1;
    check("ab_busy", busy, 0);
    check("ab_outs", {gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we}, 0);
    check("ab_rdata", {rdata0, rdata1}, 0);
    #1 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= rvalid0 | rvalid1 | gnt0 | gnt1;
    end
    check("ab_no_late", seen, 0);
    wait_idle("ab_idle");
    req0 = 1; we0 = 0; addr0 = 6'h10;
    tick();
    check("ab_next_gnt", gnt0, 1);
    req0 = 0;
    tick();
`ifdef RAM_ARBITER_INIT_EN
    check("ab_next_rdata", {rvalid0, rdata0}, {1'b1, 8'h00});
`else
    check("ab_next_rdata", {rvalid0, rdata0}, {1'b1, 8'hA5});
`endif
    tick();

`ifdef RAM_ARBITER_INIT_EN
    // Preload, reset, and confirm the sweep clears it while holding off requests.
    pre_en = 1; pre_addr = 6'd5; pre_data = 8'hFF;
    tick();
    pre_en = 0;
    rst = 1'b0;
    #2 rst = 1'b1;
    req0 = 1; we0 = 0; addr0 = 6'd5;
    tick();
    cnt = 0;
    seen = 1'b0;
    init_ok = 1'b1;
    while (busy && cnt < 200) begin
      seen |= gnt0 | gnt1;
      if (!(ram_en && ram_we && ram_din == 8'h00)) init_ok = 1'b0;
      cnt++;
      tick();
    end
    check("init_cycles", cnt, 64);
    check("init_no_gnt", seen, 0);
    check("init_writes", init_ok, 1);
    tick();
    check("init_gnt0", gnt0, 1);
    req0 = 0;
    tick();
    check("init_rdata", {rvalid0, rdata0}, {1'b1, 8'h00});
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
